// File: rtl/noc_flit_rx_port.sv
// Credit-based NoC input port: buffers flits from the link, presents them to the
// router core over valid/ready, returns one credit per dequeued flit.
module noc_flit_rx_port #(
    parameter int TDEST_WIDTH       = 3,
    parameter int FLIT_WIDTH        = 128,
    parameter int FLIT_BUFFER_DEPTH = 4
) (
    input  logic                                 clk_noc,
    input  logic                                 rst_n_noc_sync,
    input  logic [FLIT_WIDTH-1:0]                data_in,
    input  logic [TDEST_WIDTH-1:0]               dest_in,
    input  logic                                 is_tail_in,
    input  logic                                 send_in,
    output logic                                 credit_out,
    output logic                                 flit_valid,
    input  logic                                 flit_ready,
    output logic [FLIT_WIDTH-1:0]                flit_data,
    output logic [TDEST_WIDTH-1:0]               flit_dest,
    output logic                                 flit_tail,
    output logic                                 flit_head,
    output logic [$clog2(FLIT_BUFFER_DEPTH):0]   occupancy,
    output logic                                 overflow_err,
    output logic                                 framing_err
);

    localparam int PTR_W = $clog2(FLIT_BUFFER_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FLIT_BUFFER_DEPTH);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0]  data;
        logic [TDEST_WIDTH-1:0] dest;
        logic                   tail;
        logic                   head;
    } entry_t;

    typedef enum logic {
        IN_IDLE,
        IN_PKT
    } in_state_e;

    entry_t                 mem_q [FLIT_BUFFER_DEPTH];
    entry_t                 wr_entry;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   credit_q;
    logic                   overflow_q, overflow_d;
    logic                   framing_q, framing_d;
    logic                   out_head_q, out_head_d;
    in_state_e              state_q, state_d;
    logic [TDEST_WIDTH-1:0] pkt_dest_q, pkt_dest_d;
    logic                   push, pop, head_bit;
    entry_t                 rd_entry;

    assign rd_entry = mem_q[rd_ptr_q];
    assign pop      = (count_q != '0) && flit_ready;
    // A full buffer still accepts a flit when a slot frees in the same cycle.
    assign push     = send_in && ((count_q < DEPTH_CNT) || pop);

    // NOTE: every signal written in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pkt_dest_d = pkt_dest_q;
        framing_d  = framing_q;
        head_bit   = 1'b1;
        if (push) begin
            unique case (state_q)
                IN_IDLE: begin
                    head_bit = 1'b1;
                    if (!is_tail_in) begin
                        pkt_dest_d = dest_in;
                        state_d    = IN_PKT;
                    end
                end
                IN_PKT: begin
                    head_bit = 1'b0;
                    if (dest_in != pkt_dest_q) framing_d = 1'b1;
                    if (is_tail_in) state_d = IN_IDLE;
                end
                default: state_d = IN_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_entry   = '{data: data_in, dest: dest_in, tail: is_tail_in, head: head_bit};
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q || (send_in && !push);
        out_head_d = pop ? rd_entry.tail : out_head_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk_noc or negedge rst_n_noc_sync) begin
        if (!rst_n_noc_sync) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
            framing_q  <= 1'b0;
            out_head_q <= 1'b1;
            state_q    <= IN_IDLE;
            pkt_dest_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= pop;
            overflow_q <= overflow_d;
            framing_q  <= framing_d;
            out_head_q <= out_head_d;
            state_q    <= state_d;
            pkt_dest_q <= pkt_dest_d;
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries
    // are valid, and leaving the array unreset keeps it in plain RAM cells.
    always_ff @(posedge clk_noc) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign flit_valid   = (count_q != '0);
    assign flit_data    = rd_entry.data;
    assign flit_dest    = rd_entry.dest;
    assign flit_tail    = rd_entry.tail;
    // While empty, report whether the next flit to arrive will start a packet.
    assign flit_head    = flit_valid ? rd_entry.head : out_head_q;
    assign occupancy    = count_q;
    assign credit_out   = credit_q;
    assign overflow_err = overflow_q;
    assign framing_err  = framing_q;

endmodule

// File: tb/tb_noc_flit_rx_port.sv
// Directed self-checking bench for noc_flit_rx_port: single flit, fill/drain,
// push+pop on full, overflow, framing and asynchronous mid-operation reset.
module tb_noc_flit_rx_port;

    localparam int TW = 3;
    localparam int FW = 128;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk_noc = 1'b0;
    logic          rst_n_noc_sync;
    logic [FW-1:0] data_in;
    logic [TW-1:0] dest_in;
    logic          is_tail_in;
    logic          send_in;
    logic          credit_out;
    logic          flit_valid;
    logic          flit_ready;
    logic [FW-1:0] flit_data;
    logic [TW-1:0] flit_dest;
    logic          flit_tail;
    logic          flit_head;
    logic [CW-1:0] occupancy;
    logic          overflow_err;
    logic          framing_err;

    int checks   = 0;
    int failures = 0;

    noc_flit_rx_port #(
        .TDEST_WIDTH      (TW),
        .FLIT_WIDTH       (FW),
        .FLIT_BUFFER_DEPTH(D)
    ) dut (
        .clk_noc       (clk_noc),
        .rst_n_noc_sync(rst_n_noc_sync),
        .data_in       (data_in),
        .dest_in       (dest_in),
        .is_tail_in    (is_tail_in),
        .send_in       (send_in),
        .credit_out    (credit_out),
        .flit_valid    (flit_valid),
        .flit_ready    (flit_ready),
        .flit_data     (flit_data),
        .flit_dest     (flit_dest),
        .flit_tail     (flit_tail),
        .flit_head     (flit_head),
        .occupancy     (occupancy),
        .overflow_err  (overflow_err),
        .framing_err   (framing_err)
    );

    always #5 clk_noc = ~clk_noc;

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic push_flits(input int n, input int base, input logic [TW-1:0] dest);
        for (int i = 0; i < n; i++) begin
            send_in    = 1'b1;
            data_in    = FW'(base + i);
            dest_in    = dest;
            is_tail_in = 1'b1;
            tick();
            checks++;
            if (credit_out !== 1'b0) begin
                failures++;
                $display("FAIL fill_credit flit %0d: got %b want 0", i, credit_out);
            end
        end
        send_in = 1'b0;
    endtask

    task automatic drain(input string name, input int n, input int base);
        flit_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (flit_valid !== 1'b1 || flit_data !== FW'(base + i)) begin
                failures++;
                $display("FAIL %s_data[%0d]: got valid=%b data=%h want valid=1 data=%h",
                         name, i, flit_valid, flit_data, FW'(base + i));
            end
            tick();
            checks++;
            if (credit_out !== 1'b1) begin
                failures++;
                $display("FAIL %s_credit[%0d]: got %b want 1", name, i, credit_out);
            end
        end
        flit_ready = 1'b0;
        checks++;
        if (occupancy !== CW'(0) || flit_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_empty: got occ=%0d valid=%b want 0/0", name, occupancy, flit_valid);
        end
        tick();
        checks++;
        if (credit_out !== 1'b0) begin
            failures++;
            $display("FAIL %s_credit_end: got %b want 0", name, credit_out);
        end
    endtask

    task automatic test_reset();
        rst_n_noc_sync = 1'b0;
        send_in = 1'b0; flit_ready = 1'b0; data_in = '0; dest_in = '0; is_tail_in = 1'b0;
        repeat (3) @(posedge clk_noc);
        @(negedge clk_noc);
        rst_n_noc_sync = 1'b1;
        tick();
        checks++;
        if (credit_out !== 1'b0 || flit_valid !== 1'b0 || occupancy !== CW'(0) ||
            overflow_err !== 1'b0 || framing_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got credit=%b valid=%b occ=%0d ovf=%b frm=%b want all 0",
                     credit_out, flit_valid, occupancy, overflow_err, framing_err);
        end
    endtask

    task automatic test_single_flit();
        flit_ready = 1'b1;
        send_in = 1'b1; data_in = FW'(8'hA5); dest_in = 3'd2; is_tail_in = 1'b1;
        tick();
        send_in = 1'b0;
        checks++;
        if (flit_valid !== 1'b1 || flit_head !== 1'b1 || flit_tail !== 1'b1 ||
            flit_dest !== 3'd2 || flit_data !== FW'(8'hA5) || occupancy !== CW'(1) ||
            credit_out !== 1'b0) begin
            failures++;
            $display("FAIL single_out: got v=%b h=%b t=%b dst=%0d data=%h occ=%0d cr=%b want 1 1 1 2 a5 1 0",
                     flit_valid, flit_head, flit_tail, flit_dest, flit_data, occupancy, credit_out);
        end
        tick();
        flit_ready = 1'b0;
        checks++;
        if (credit_out !== 1'b1 || occupancy !== CW'(0) || flit_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pop: got cr=%b occ=%0d v=%b want 1 0 0", credit_out, occupancy, flit_valid);
        end
        tick();
        checks++;
        if (credit_out !== 1'b0) begin
            failures++;
            $display("FAIL single_credit_width: got %b want 0", credit_out);
        end
    endtask

    task automatic test_fill_drain();
        flit_ready = 1'b0;
        push_flits(D, 'h10, 3'd1);
        checks++;
        if (occupancy !== CW'(D) || flit_valid !== 1'b1) begin
            failures++;
            $display("FAIL fill_full: got occ=%0d v=%b want %0d 1", occupancy, flit_valid, D);
        end
        tick();
        checks++;
        if (credit_out !== 1'b0 || occupancy !== CW'(D) || flit_data !== FW'('h10)) begin
            failures++;
            $display("FAIL fill_hold: got cr=%b occ=%0d data=%h want 0 %0d 10", credit_out, occupancy, flit_data, D);
        end
        drain("fill", D, 'h10);
    endtask

    task automatic test_push_pop_full();
        push_flits(D, 'h20, 3'd3);
        send_in = 1'b1; data_in = FW'('h24); dest_in = 3'd3; is_tail_in = 1'b1;
        flit_ready = 1'b1;
        tick();
        send_in = 1'b0; flit_ready = 1'b0;
        checks++;
        if (occupancy !== CW'(D) || overflow_err !== 1'b0 || credit_out !== 1'b1) begin
            failures++;
            $display("FAIL ppfull: got occ=%0d ovf=%b cr=%b want %0d 0 1", occupancy, overflow_err, credit_out, D);
        end
        tick();
        checks++;
        if (credit_out !== 1'b0) begin
            failures++;
            $display("FAIL ppfull_credit: got %b want 0", credit_out);
        end
        drain("ppfull", D, 'h21);
    endtask

    task automatic test_overflow();
        push_flits(D, 'h30, 3'd4);
        send_in = 1'b1; data_in = FW'('hEE); dest_in = 3'd4; is_tail_in = 1'b1;
        tick();
        send_in = 1'b0;
        checks++;
        if (overflow_err !== 1'b1 || occupancy !== CW'(D) || credit_out !== 1'b0) begin
            failures++;
            $display("FAIL overflow_set: got ovf=%b occ=%0d cr=%b want 1 %0d 0", overflow_err, occupancy, credit_out, D);
        end
        tick();
        checks++;
        if (overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: got %b want 1", overflow_err);
        end
        drain("overflow", D, 'h30);
        checks++;
        if (overflow_err !== 1'b1 || framing_err !== 1'b0) begin
            failures++;
            $display("FAIL overflow_after: got ovf=%b frm=%b want 1 0", overflow_err, framing_err);
        end
    endtask

    task automatic test_framing();
        logic [TW-1:0] dests [4];
        logic          tails [4];
        logic          heads [4];
        logic          frm   [4];
        dests = '{3'd5, 3'd5, 3'd3, 3'd5};
        tails = '{1'b0, 1'b0, 1'b0, 1'b1};
        heads = '{1'b1, 1'b0, 1'b0, 1'b0};
        frm   = '{1'b0, 1'b0, 1'b1, 1'b1};
        flit_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_in = 1'b1; data_in = FW'('h40 + i); dest_in = dests[i]; is_tail_in = tails[i];
            tick();
            checks++;
            if (framing_err !== frm[i]) begin
                failures++;
                $display("FAIL framing_err[%0d]: got %b want %b", i, framing_err, frm[i]);
            end
        end
        send_in = 1'b0;
        flit_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (flit_valid !== 1'b1 || flit_data !== FW'('h40 + i) || flit_dest !== dests[i] ||
                flit_head !== heads[i] || flit_tail !== tails[i]) begin
                failures++;
                $display("FAIL framing_flit[%0d]: got v=%b data=%h dst=%0d h=%b t=%b want 1 %h %0d %b %b",
                         i, flit_valid, flit_data, flit_dest, flit_head, flit_tail,
                         FW'('h40 + i), dests[i], heads[i], tails[i]);
            end
            tick();
        end
        flit_ready = 1'b0;
        checks++;
        if (occupancy !== CW'(0) || framing_err !== 1'b1) begin
            failures++;
            $display("FAIL framing_end: got occ=%0d frm=%b want 0 1", occupancy, framing_err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        push_flits(3, 'h50, 3'd6);
        #2;
        rst_n_noc_sync = 1'b0;
        #1;
        checks++;
        if (occupancy !== CW'(0) || flit_valid !== 1'b0 || overflow_err !== 1'b0 ||
            framing_err !== 1'b0 || credit_out !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: got occ=%0d v=%b ovf=%b frm=%b cr=%b want all 0",
                     occupancy, flit_valid, overflow_err, framing_err, credit_out);
        end
        flit_ready = 1'b1;
        repeat (2) @(posedge clk_noc);
        @(negedge clk_noc);
        rst_n_noc_sync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (credit_out !== 1'b0 || flit_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_quiet[%0d]: got cr=%b v=%b want 0 0", i, credit_out, flit_valid);
            end
        end
        flit_ready = 1'b0;
        push_flits(1, 'h60, 3'd7);
        checks++;
        if (flit_data !== FW'('h60) || flit_head !== 1'b1 || occupancy !== CW'(1)) begin
            failures++;
            $display("FAIL rstmid_new: got data=%h h=%b occ=%0d want 60 1 1", flit_data, flit_head, occupancy);
        end
        drain("rstmid", 1, 'h60);
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_fill_drain();
        test_push_pop_full();
        test_overflow();
        test_framing();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_flit_rx_port.md
Name: noc_flit_rx_port

Overview:
- Single-clock, credit-based flit receiver at a NoC router input port.
- Terminates the link driven by the AXIS serializer shim (data/dest/is_tail/send in, credit out).
- Buffers up to FLIT_BUFFER_DEPTH flits and presents them to the router core over a valid/ready interface.
- Returns one credit per dequeued flit and flags link-protocol violations.

Parameters:
- TDEST_WIDTH, 3, width of the destination field.
- FLIT_WIDTH, 128, flit payload width.
- FLIT_BUFFER_DEPTH, 4, buffer entries. Must equal the sender's initial credit count; power of two, ≥2.

Ports:
- clk_noc  input  1  NoC clock.
- rst_n_noc_sync  input  1  reset, asynchronous, active-low.
- data_in  input  FLIT_WIDTH  flit payload.
- dest_in  input  TDEST_WIDTH  flit destination.
- is_tail_in  input  1  last flit of packet.
- send_in  input  1  flit present this cycle (no backpressure).
- credit_out  output  1  one-cycle pulse = one buffer slot freed.
- flit_valid  output  1  head-of-buffer flit available.
- flit_ready  input  1  router core accepts flit.
- flit_data  output  FLIT_WIDTH  buffered payload.
- flit_dest  output  TDEST_WIDTH  buffered destination.
- flit_tail  output  1  buffered tail flag.
- flit_head  output  1  buffered flit is first of its packet.
- occupancy  output  $clog2(FLIT_BUFFER_DEPTH)+1  flits stored.
- overflow_err  output  1  sticky: flit arrived with buffer full.
- framing_err  output  1  sticky: dest changed mid-packet.

Behaviour:
- Reset (async assert, clk_noc-synchronous deassert inside the reset generator):
  - credit_out=0, flit_valid=0, occupancy=0, overflow_err=0, framing_err=0.
  - flit_head reflects an empty buffer; its value is don't-care while flit_valid=0.
  - Read/write pointers=0, input packet FSM=IN_IDLE, output head tracker=1.
- Storage:
  - Circular buffer of {data, dest, tail, head}. Write/read pointers wrap modulo FLIT_BUFFER_DEPTH. A count register drives occupancy.
  - Push = send_in & (count<DEPTH | pop). Pop = flit_valid & flit_ready.
- Latency: flit written on send_in edge appears on flit_* with flit_valid=1 the next cycle (first-word-fall-through, outputs from registered buffer state).
- Handshake:
  - flit_* stable while flit_valid & ~flit_ready.
  - flit_valid = (count>0).
- Credit return: credit_out registered, equals pop of previous cycle; exactly one pulse per popped flit; never pulses for dropped flits.
- Simultaneous events:
  - Push+pop on empty: no bypass, flit appears the following cycle.
  - Push+pop on full: both occur, count stays DEPTH, no overflow.
  - Push+pop at any other count: count unchanged, pointers both advance.
- Full boundary: send_in with count==DEPTH and no pop → flit dropped, overflow_err set (sticky until reset), count unchanged.
- Empty boundary: flit_ready while count==0 ignored.
- Input packet FSM (evaluated on accepted pushes only):
  - IN_IDLE: push with is_tail_in=0 → latch dest_in, go IN_PKT. Push with is_tail_in=1 stays IN_IDLE (single-flit packet). Stored head bit=1.
  - IN_PKT: stored head bit=0. If dest_in≠latched dest → framing_err set (sticky), flit still stored. Push with is_tail_in=1 → IN_IDLE.
- flit_head = stored head bit of current read entry.
- Reset mid-operation: buffered flits discarded, no credits emitted for them. The sender is reset in the same reset domain and restores its credits to FLIT_BUFFER_DEPTH.

Test Plan:
- Single-flit packet: send_in 1 cycle, data=0xA5, dest=2, tail=1, flit_ready=1 → flit_valid next cycle with flit_head=1, flit_tail=1, flit_dest=2. credit_out pulses one cycle after the pop. occupancy returns to 0.
- Fill to full: 4 consecutive sends, flit_ready=0 → occupancy=4, flit_valid=1, no credit_out. Then flit_ready=1 for 4 cycles → 4 flits in order, 4 credit_out pulses, each one cycle after its pop.
- Push+pop on full: occupancy=4, send_in and flit_ready in the same cycle → occupancy stays 4, overflow_err=0, one credit_out pulse.
- Overflow: occupancy=4, flit_ready=0, send_in=1 → flit dropped, overflow_err=1 and held, occupancy=4. The 4 original flits drain unchanged.
- Framing: 4-flit packet dest=5,5,3,5 with tail on flit 4 → framing_err=1 after the 3rd flit. All 4 flits delivered with head pattern 1,0,0,0 and tail pattern 0,0,0,1.
- Reset mid-operation: 3 flits buffered, assert rst_n_noc_sync=0 asynchronously → occupancy=0, flit_valid=0, errors=0 immediately. No credit_out during or after reset until new flits are popped.
